// File: rtl/closest_hit_select.sv
// Closest-hit selector: folds NUM_SPHERES candidate t values per ray
// into the nearest valid hit (t, sphere index, hit flag).
module closest_hit_select #(
  parameter int SIZE = 64,
  parameter int NUM_SPHERES = 8,
  parameter logic [SIZE-1:0] T_MIN = 64'h3F50624DD2F1A9FC,
  localparam int IDX_W = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [SIZE-1:0]  t_axis_tdata,
  input  logic             t_axis_tvalid,
  output logic             t_axis_tready,
  output logic [SIZE-1:0]  hit_axis_t,
  output logic [IDX_W-1:0] hit_axis_idx,
  output logic             hit_axis_hit,
  output logic             hit_axis_tvalid,
  input  logic             hit_axis_tready
);

  localparam logic [SIZE-1:0] INF = 64'h7FF0000000000000;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SPHERES - 1);

  typedef enum logic {
    ACCUM,
    OUTPUT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] sphere_cnt;
  logic [SIZE-1:0]  best_t;
  logic [IDX_W-1:0] best_idx;
  logic             best_vld;

  logic             cand_ok;
  logic             better;
  logic             take;
  logic             last;
  logic [SIZE-1:0]  nxt_t;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_vld;

  // Candidate qualification and running-minimum update including this beat.
  // Unsigned ordering matches numeric ordering for positive finite doubles.
  always_comb begin
    cand_ok = !t_axis_tdata[SIZE-1]
           && (t_axis_tdata[SIZE-2:SIZE-12] != 11'h7FF)
           && (t_axis_tdata > T_MIN);
    better  = cand_ok && (!best_vld || (t_axis_tdata < best_t));
    take    = t_axis_tvalid && t_axis_tready && (state == ACCUM);
    last    = (sphere_cnt == LAST);
    nxt_t   = better ? t_axis_tdata : best_t;
    nxt_idx = better ? sphere_cnt : best_idx;
    nxt_vld = best_vld || better;
  end

  // Ray accumulation / result hold state machine with registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= ACCUM;
      sphere_cnt      <= '0;
      best_t          <= '0;
      best_idx        <= '0;
      best_vld        <= 1'b0;
      t_axis_tready   <= 1'b1;
      hit_axis_tvalid <= 1'b0;
      hit_axis_t      <= '0;
      hit_axis_idx    <= '0;
      hit_axis_hit    <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (take) begin
            if (last) begin
              hit_axis_t      <= nxt_vld ? nxt_t : INF;
              hit_axis_idx    <= nxt_vld ? nxt_idx : '0;
              hit_axis_hit    <= nxt_vld;
              hit_axis_tvalid <= 1'b1;
              t_axis_tready   <= 1'b0;
              sphere_cnt      <= '0;
              best_vld        <= 1'b0;
              state           <= OUTPUT;
            end else begin
              best_t     <= nxt_t;
              best_idx   <= nxt_idx;
              best_vld   <= nxt_vld;
              sphere_cnt <= sphere_cnt + IDX_W'(1);
            end
          end
        end
        OUTPUT: begin
          if (hit_axis_tready) begin
            hit_axis_tvalid <= 1'b0;
            t_axis_tready   <= 1'b1;
            state           <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
